// File: rtl/uart_debug_rx_pkg.sv
// Shared constants for the debug-link UART: default line settings, receiver
// state encodings and the oversample divider calculation.
package uart_debug_rx_pkg;

  localparam int DEFAULT_CLK_FREQ   = 51_000_000;
  localparam int DEFAULT_BAUD       = 115_200;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int BYTE_W             = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int ticks_per_s;
    ticks_per_s = baud * oversample;
    return (clk_freq + ticks_per_s / 2) / ticks_per_s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO for the debug UART: wrap-bit pointers, no bypass path,
// overrun pulse when a byte arrives into a full FIFO that is not being popped.
module uart_rx_fifo
  import uart_debug_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              not_empty,
  output logic              overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              do_pop;
  logic              do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign not_empty = !empty;

endmodule

// File: rtl/uart_debug_rx.sv
// Debug-link UART receiver: synchronises the FTDI line, recovers 8N1 bytes by
// oversampling and hands them to the command decoder through a small FIFO.
module uart_debug_rx
  import uart_debug_rx_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_uart_rx,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_frame_err,
  output logic        o_overrun,
  output logic        o_busy
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TC_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  TC_HALF  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVERSAMPLE - 1);

  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       state;
  logic [TC_W-1:0]  tc;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             frame_err;
  logic             start_edge;
  logic             bit_centre;
  logic             push;
  logic             pop;

  // Input synchroniser; both flops reset to the idle-high line level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign start_edge = (state == ST_IDLE) && !rx_s;
  assign tick       = (div_cnt == DIV_LAST);
  assign bit_centre = tick && (tc == TC_LAST);

  // Tick divider, re-phased to the start edge so sample points sit mid-bit.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_edge || tick) div_cnt <= '0;
    else                             div_cnt <= div_cnt + 1'b1;
  end

  // Receiver FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      tc        <= '0;
      bit_idx   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            tc    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tc == TC_HALF) begin
              tc      <= '0;
              bit_idx <= '0;
              state   <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tc <= tc + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tc == TC_LAST) begin
              tc <= '0;
              if (bit_idx == 3'd7) state   <= ST_STOP;
              else                 bit_idx <= bit_idx + 1'b1;
            end else begin
              tc <= tc + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tc == TC_LAST) begin
              tc <= '0;
              if (rx_s) begin
                state <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_IDLE;
              end
            end else begin
              tc <= tc + 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if ((state == ST_DATA) && bit_centre) shreg <= {rx_s, shreg[7:1]};
  end

  assign push = (state == ST_STOP) && bit_centre && rx_s;
  assign pop  = o_valid && i_ready;

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (o_data),
    .not_empty (o_valid),
    .overrun   (o_overrun)
  );

  assign o_frame_err = frame_err;
  assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_debug_rx.sv
// Directed bench for uart_debug_rx: drives 8N1 frames at 115200 baud and
// checks received bytes against a scoreboard queue.
module tb_uart_debug_rx;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_uart_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  localparam int BIT_CLKS = 448;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rx_cnt = 0;
  int valid_cycles = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_debug_rx dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int bit_clks, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_uart_rx = frame[i];
      idle(bit_clks);
    end
    i_uart_rx = 1'b1;
  endtask

  task automatic clear_counts();
    fe_cnt = 0;
    ov_cnt = 0;
    rx_cnt = 0;
    valid_cycles = 0;
  endtask

  // Output monitor: sampled on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (o_frame_err === 1'b1) fe_cnt++;
    if (o_overrun === 1'b1) ov_cnt++;
    if (o_valid === 1'b1) valid_cycles++;
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_byte observed=%0h expected=none", o_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = exp_q.pop_front();
        checks++;
        assert (o_data === exp_b) else begin
          errors++;
          $error("FAIL rx_byte observed=%0h expected=%0h", o_data, exp_b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    idle(5);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_frame_err", 32'(o_frame_err), 32'h0);
    check("rst_overrun", 32'(o_overrun), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    i_rst = 1'b0;
    idle(50);

    // 1: single byte with consumer ready
    clear_counts();
    i_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, BIT_CLKS, 1'b1);
    check("t1_busy_after_stop", 32'(o_busy), 32'h0);
    idle(20);
    check("t1_rx_count", rx_cnt, 1);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_frame_err", fe_cnt, 0);

    // Tolerance: +/-2.5% line rate
    clear_counts();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 459, 1'b1);
    idle(20);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 437, 1'b1);
    idle(20);
    check("tol_rx_count", rx_cnt, 2);
    check("tol_frame_err", fe_cnt, 0);

    // 2: fill FIFO with consumer stalled, fifth byte overruns
    clear_counts();
    i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), BIT_CLKS, 1'b1);
    end
    idle(20);
    check("t2_no_overrun_yet", ov_cnt, 0);
    send_byte(8'h55, BIT_CLKS, 1'b1);
    idle(20);
    check("t2_overrun_pulse", ov_cnt, 1);
    check("t2_valid_held", 32'(o_valid), 32'h1);
    check("t2_data_held", 32'(o_data), 32'h01);
    i_ready = 1'b1;
    idle(20);
    check("t2_drain_count", rx_cnt, 4);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_valid_after_drain", 32'(o_valid), 32'h0);

    // 3: short low glitch on idle line
    clear_counts();
    i_uart_rx = 1'b0;
    idle(50);
    check("t3_busy_in_glitch", 32'(o_busy), 32'h1);
    idle(50);
    i_uart_rx = 1'b1;
    idle(600);
    check("t3_busy_after", 32'(o_busy), 32'h0);
    check("t3_no_valid", valid_cycles, 0);
    check("t3_no_frame_err", fe_cnt, 0);

    // 4: framing error followed by a break, then a good byte
    clear_counts();
    send_byte(8'h3C, BIT_CLKS, 1'b0);
    i_uart_rx = 1'b0;
    idle(2000);
    check("t4_busy_in_break", 32'(o_busy), 32'h1);
    i_uart_rx = 1'b1;
    idle(50);
    check("t4_busy_after_break", 32'(o_busy), 32'h0);
    check("t4_one_frame_err", fe_cnt, 1);
    check("t4_no_byte", rx_cnt, 0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, BIT_CLKS, 1'b1);
    idle(20);
    check("t4_next_byte_count", rx_cnt, 1);
    check("t4_frame_err_total", fe_cnt, 1);

    // 5: reset during bit 4 of 0xFF
    clear_counts();
    i_uart_rx = 1'b0;
    idle(BIT_CLKS);
    i_uart_rx = 1'b1;
    idle(4 * BIT_CLKS + 200);
    check("t5_busy_before_rst", 32'(o_busy), 32'h1);
    i_rst = 1'b1;
    idle(1);
    i_rst = 1'b0;
    check("t5_rst_busy", 32'(o_busy), 32'h0);
    check("t5_rst_valid", 32'(o_valid), 32'h0);
    check("t5_rst_data", 32'(o_data), 32'h0);
    check("t5_rst_frame_err", 32'(o_frame_err), 32'h0);
    check("t5_rst_overrun", 32'(o_overrun), 32'h0);
    idle(500);
    exp_q.push_back(8'h12);
    send_byte(8'h12, BIT_CLKS, 1'b1);
    idle(20);
    check("t5_rx_count", rx_cnt, 1);
    check("t5_frame_err", fe_cnt, 0);

    // 6: pop coincides with the fifth byte's push into a full FIFO
    clear_counts();
    i_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, BIT_CLKS, 1'b1);
    exp_q.push_back(8'h22);
    send_byte(8'h22, BIT_CLKS, 1'b1);
    exp_q.push_back(8'h33);
    send_byte(8'h33, BIT_CLKS, 1'b1);
    exp_q.push_back(8'h44);
    send_byte(8'h44, BIT_CLKS, 1'b1);
    idle(20);
    exp_q.push_back(8'h99);
    // Line falls just after edge k; stop-bit sample lands on edge k+4259.
    fork
      send_byte(8'h99, BIT_CLKS, 1'b1);
      begin
        idle(4258);
        i_ready = 1'b1;
        idle(1);
        i_ready = 1'b0;
      end
    join
    idle(20);
    check("t6_no_overrun", ov_cnt, 0);
    check("t6_one_popped", rx_cnt, 1);
    i_ready = 1'b1;
    idle(20);
    check("t6_drain_count", rx_cnt, 5);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
